// File: rtl/lsram_apb_arbiter.sv
// Two-requester round-robin arbiter and APB3 master sequencer for the LSRAM APB slave.
// Optional ACCESS-phase timeout: define LSRAM_ARB_TIMEOUT_EN.
module lsram_apb_arbiter #(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic [1:0]            REQ,
  input  logic [1:0]            REQ_WRITE,
  input  logic [2*ADDR_W-1:0]   REQ_ADDR,
  input  logic [2*DATA_W-1:0]   REQ_WDATA,
  output logic [1:0]            ACK,
  output logic [DATA_W-1:0]     RDATA,
  output logic                  ERR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_e;

  state_e              state_q,   state_d;
  logic                psel_q,    psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q,  pwrite_d;
  logic [ADDR_W-1:0]   paddr_q,   paddr_d;
  logic [DATA_W-1:0]   pwdata_q,  pwdata_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;
  logic                err_q,     err_d;
  logic [1:0]          ack_q,     ack_d;
  logic                last_q,    last_d;
  logic                grant_q,   grant_d;
  logic [1:0]          eligible;
  logic                winner;
  logic                tmo_expired;

`ifdef LSRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts ACCESS cycles with PREADY low; zero everywhere else, so it is clear on SETUP entry.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_ACCESS && !PREADY) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end

  assign tmo_expired = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expired = 1'b0;
`endif

  // The requester being ACKed this cycle is still holding REQ and must not be re-granted.
  assign eligible = REQ & ~ack_q;
  assign winner   = (&eligible) ? ~last_q : eligible[1];

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ack_d     = 2'b00;
    last_d    = last_q;
    grant_d   = grant_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          grant_d   = winner;
          last_d    = winner;
          pwrite_d  = REQ_WRITE[winner];
          paddr_d   = winner ? REQ_ADDR[2*ADDR_W-1:ADDR_W]   : REQ_ADDR[ADDR_W-1:0];
          pwdata_d  = winner ? REQ_WDATA[2*DATA_W-1:DATA_W] : REQ_WDATA[DATA_W-1:0];
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // PREADY wins over a simultaneous timeout expiry.
        if (PREADY || tmo_expired) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = grant_q ? 2'b10 : 2'b01;
          rdata_d   = (PREADY && !pwrite_q) ? PRDATA : '0;
          err_d     = PREADY ? PSLVERR : 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q   <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ack_q     <= 2'b00;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign RDATA   = rdata_q;
  assign ERR     = err_q;
  assign ACK     = ack_q;

endmodule

// File: tb/tb_lsram_apb_arbiter.sv
// Self-checking bench for lsram_apb_arbiter: directed scenarios plus a randomized run
// against a transfer-level model of the arbitration and APB timing rules.
module tb_lsram_apb_arbiter;
  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic              PCLK = 1'b0;
  logic              PRESETN;
  logic [1:0]        REQ;
  logic [1:0]        REQ_WRITE;
  logic [2*AW-1:0]   REQ_ADDR;
  logic [2*DW-1:0]   REQ_WDATA;
  logic [1:0]        ACK;
  logic [DW-1:0]     RDATA;
  logic              ERR;
  logic              PSEL, PENABLE, PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [DW-1:0]     PRDATA;
  logic              PREADY, PSLVERR;

  int tests_run    = 0;
  int tests_failed = 0;

  // Slave model state
  logic [DW-1:0] smem [2048];
  int            next_waits = 0;
  bit            next_err   = 1'b0;
  int            waits_left;

  lsram_apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .ACK(ACK), .RDATA(RDATA), .ERR(ERR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // APB slave: inserts next_waits low-PREADY cycles per access, memory-backed.
  initial begin
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0; waits_left = 0;
    forever begin
      @(posedge PCLK); #2;
      if (PSEL && !PENABLE) begin
        waits_left = next_waits;
        PREADY = 1'b0; PSLVERR = 1'b0;
      end else if (PSEL && PENABLE) begin
        if (waits_left > 0) begin
          waits_left--;
          PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = DW'($urandom);
        end else begin
          PREADY = 1'b1; PSLVERR = next_err;
          if (PWRITE) begin
            PRDATA = DW'($urandom);
            if (!next_err) smem[PADDR[10:0]] = PWDATA;
          end else begin
            PRDATA = smem[PADDR[10:0]];
          end
        end
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge PCLK); #1;
  endtask

  task automatic set_req(input int n, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    REQ_WRITE[n]       = wr;
    REQ_ADDR[n*AW +: AW] = a;
    REQ_WDATA[n*DW +: DW] = d;
  endtask

  task automatic test_reset();
    PRESETN = 1'b0; REQ = 2'b00; REQ_WRITE = 2'b00; REQ_ADDR = '0; REQ_WDATA = '0;
    tick();
    tests_run++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ctrl: got psel/penable/pwrite=%b want 000", {PSEL, PENABLE, PWRITE});
    end
    tests_run++;
    if (PADDR !== '0 || PWDATA !== '0 || RDATA !== '0) begin
      tests_failed++; $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h want 0", PADDR, PWDATA, RDATA);
    end
    tests_run++;
    if (ACK !== 2'b00 || ERR !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ack: got ack=%b err=%b want 00/0", ACK, ERR);
    end
    tick();
    PRESETN = 1'b1;
  endtask

  task automatic test_single_write();
    next_waits = 0; next_err = 1'b0;
    set_req(0, 1'b1, 20'h00010, 16'hA5C3);
    REQ = 2'b01;
    tick();
    tests_run++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== 1'b1 || PADDR !== 20'h00010 || PWDATA !== 16'hA5C3 || ACK !== 2'b00) begin
      tests_failed++;
      $display("FAIL write_setup: got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h ack=%b want 1 0 1 00010 a5c3 00",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, ACK);
    end
    tick();
    tests_run++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PWDATA !== 16'hA5C3 || ACK !== 2'b00) begin
      tests_failed++;
      $display("FAIL write_access: got psel=%b pen=%b pwdata=%h ack=%b want 1 1 a5c3 00", PSEL, PENABLE, PWDATA, ACK);
    end
    tick();
    tests_run++;
    if (ACK !== 2'b01 || ERR !== 1'b0 || RDATA !== '0 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_ack: got ack=%b err=%b rdata=%h psel=%b pen=%b want 01 0 0000 0 0", ACK, ERR, RDATA, PSEL, PENABLE);
    end
    REQ = 2'b00;
    tick();
    tests_run++;
    if (ACK !== 2'b00) begin
      tests_failed++; $display("FAIL write_ack_pulse: got ack=%b want 00", ACK);
    end
  endtask

  task automatic test_read_wait();
    int n;
    bit stable;
    next_waits = 4; next_err = 1'b0;
    set_req(1, 1'b0, 20'h00010, 16'h0000);
    REQ = 2'b10;
    n = 0; stable = 1'b1;
    do begin
      tick(); n++;
      if (PSEL === 1'b1 && PADDR !== 20'h00010) stable = 1'b0;
    end while (ACK === 2'b00 && n < 20);
    REQ = 2'b00;
    tests_run++;
    if (n != 7 || ACK !== 2'b10) begin
      tests_failed++; $display("FAIL read_wait_latency: got %0d cycles ack=%b want 7 cycles ack=10", n, ACK);
    end
    tests_run++;
    if (RDATA !== 16'hA5C3 || ERR !== 1'b0) begin
      tests_failed++; $display("FAIL read_wait_data: got rdata=%h err=%b want a5c3 0", RDATA, ERR);
    end
    tests_run++;
    if (!stable) begin
      tests_failed++; $display("FAIL read_wait_paddr: got PADDR changing while PSEL=1 want stable 00010");
    end
    tick();
    next_waits = 0;
  endtask

  task automatic test_contention();
    int order [6] = '{0, 1, 0, 1, 0, 1};
    int k, t, last_t;
    next_waits = 0; next_err = 1'b0;
    PRESETN = 1'b0; REQ = 2'b00;
    tick();
    set_req(0, 1'b0, 20'h00100, 16'h0);
    set_req(1, 1'b0, 20'h00200, 16'h0);
    PRESETN = 1'b1; REQ = 2'b11;
    k = 0; t = 0; last_t = 0;
    while (k < 6 && t < 40) begin
      tick(); t++;
      if (ACK !== 2'b00) begin
        tests_run++;
        if (ACK !== (order[k] == 1 ? 2'b10 : 2'b01) || (t - last_t) != 3) begin
          tests_failed++;
          $display("FAIL contention_%0d: got ack=%b after %0d cycles want requester %0d after 3 cycles",
                   k, ACK, t - last_t, order[k]);
        end
        last_t = t; k++;
      end
    end
    REQ = 2'b00;
    tests_run++;
    if (k != 6) begin
      tests_failed++; $display("FAIL contention_count: got %0d acks want 6", k);
    end
    tick();
  endtask

  task automatic test_slverr();
    int n;
    next_waits = 0; next_err = 1'b1;
    set_req(0, 1'b0, 20'h00020, 16'h0);
    REQ = 2'b01;
    n = 0;
    do begin tick(); n++; end while (ACK === 2'b00 && n < 10);
    REQ = 2'b00;
    tests_run++;
    if (ACK !== 2'b01 || ERR !== 1'b1) begin
      tests_failed++; $display("FAIL slverr_err: got ack=%b err=%b want 01 1", ACK, ERR);
    end
    tick();
    next_err = 1'b0;
    REQ = 2'b01;
    n = 0;
    do begin tick(); n++; end while (ACK === 2'b00 && n < 10);
    REQ = 2'b00;
    tests_run++;
    if (ACK !== 2'b01 || ERR !== 1'b0 || RDATA !== smem[11'h020]) begin
      tests_failed++; $display("FAIL slverr_next: got ack=%b err=%b rdata=%h want 01 0 %h", ACK, ERR, RDATA, smem[11'h020]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    next_waits = 1000; next_err = 1'b0;
    set_req(0, 1'b0, 20'h00030, 16'h0);
    REQ = 2'b01;
    tick(); tick(); tick();
    tests_run++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1 || ACK !== 2'b00) begin
      tests_failed++; $display("FAIL midreset_access: got psel=%b pen=%b ack=%b want 1 1 00", PSEL, PENABLE, ACK);
    end
    PRESETN = 1'b0; REQ = 2'b00;
    tick();
    tests_run++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || ACK !== 2'b00) begin
      tests_failed++; $display("FAIL midreset_drop: got psel=%b pen=%b ack=%b want 0 0 00", PSEL, PENABLE, ACK);
    end
    PRESETN = 1'b1; next_waits = 0;
    set_req(0, 1'b0, 20'h00040, 16'h0);
    set_req(1, 1'b0, 20'h00041, 16'h0);
    REQ = 2'b11;
    tick();
    tests_run++;
    if (PSEL !== 1'b1 || PADDR !== 20'h00040) begin
      tests_failed++; $display("FAIL midreset_first_grant: got psel=%b paddr=%h want 1 00040", PSEL, PADDR);
    end
    n = 0;
    do begin tick(); n++; end while (ACK === 2'b00 && n < 10);
    REQ = 2'b10;
    tests_run++;
    if (ACK !== 2'b01) begin
      tests_failed++; $display("FAIL midreset_first_ack: got ack=%b want 01", ACK);
    end
    n = 0;
    do begin tick(); n++; end while (ACK === 2'b00 && n < 10);
    REQ = 2'b00;
    tests_run++;
    if (ACK !== 2'b10) begin
      tests_failed++; $display("FAIL midreset_second_ack: got ack=%b want 10", ACK);
    end
    tick();
  endtask

`ifdef LSRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    next_waits = 1000; next_err = 1'b0;
    set_req(0, 1'b0, 20'h00050, 16'h0);
    REQ = 2'b01;
    n = 0;
    do begin tick(); n++; end while (ACK === 2'b00 && n < 40);
    REQ = 2'b00;
    // SETUP edge + edge into ACCESS + TMO ACCESS cycles
    tests_run++;
    if (n != TMO + 2 || ACK !== 2'b01) begin
      tests_failed++; $display("FAIL timeout_latency: got %0d cycles ack=%b want %0d cycles ack=01", n, ACK, TMO + 2);
    end
    tests_run++;
    if (ERR !== 1'b1 || RDATA !== '0 || PSEL !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_result: got err=%b rdata=%h psel=%b want 1 0000 0", ERR, RDATA, PSEL);
    end
    next_waits = 0;
    tick();
  endtask
`endif

  // Transfer-level model: a grant starts whenever the model is idle and a requester
  // is pending (excluding the one just acknowledged); ACK lands 2 + waits edges later.
  task automatic test_random();
    logic [DW-1:0] m_mem [2048];
    bit            pend [2];
    bit            wr [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic [1:0]    elig, exp_ack, prev_ack;
    bit            busy, last, t_wr, t_err, exp_err;
    int            g, grant_edge, ack_edge, w;
    logic [AW-1:0] t_ad;
    logic [DW-1:0] t_wd, exp_rdata;

    for (int i = 0; i < 2048; i++) m_mem[i] = smem[i];
    PRESETN = 1'b0; REQ = 2'b00;
    tick();
    PRESETN = 1'b1;
    busy = 1'b0; last = 1'b1; prev_ack = 2'b00; g = 0; grant_edge = 0; ack_edge = 0;
    t_wr = 1'b0; t_err = 1'b0; t_ad = '0; t_wd = '0; exp_err = 1'b0; exp_rdata = '0;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; wr[n] = 1'b0; ad[n] = '0; wd[n] = '0;
    end

    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 2) != 0) begin
          pend[n] = 1'b1;
          wr[n]   = 1'(($urandom_range(0, 1)));
          ad[n]   = AW'($urandom_range(0, 15));
          wd[n]   = DW'($urandom);
        end
      end
      REQ       = {pend[1], pend[0]};
      REQ_WRITE = {wr[1], wr[0]};
      REQ_ADDR  = {ad[1], ad[0]};
      REQ_WDATA = {wd[1], wd[0]};

      exp_ack = 2'b00;
      if (busy && cyc == ack_edge) begin
        exp_ack[g] = 1'b1;
        busy       = 1'b0;
        exp_err    = t_err;
        exp_rdata  = t_wr ? '0 : m_mem[t_ad[10:0]];
        if (t_wr && !t_err) m_mem[t_ad[10:0]] = t_wd;
        pend[g] = 1'b0;
      end else if (!busy) begin
        elig = {pend[1], pend[0]} & ~prev_ack;
        if (elig != 2'b00) begin
          g          = (elig == 2'b11) ? int'(!last) : (elig[1] ? 1 : 0);
          last       = (g == 1);
          busy       = 1'b1;
          t_wr       = wr[g]; t_ad = ad[g]; t_wd = wd[g];
          w          = $urandom_range(0, 3);
          t_err      = ($urandom_range(0, 7) == 0);
          next_waits = w; next_err = t_err;
          grant_edge = cyc;
          ack_edge   = cyc + 2 + w;
        end
      end

      tick();

      tests_run++;
      if (ACK !== exp_ack) begin
        tests_failed++; $display("FAIL random_ack cycle %0d: got ack=%b want %b", cyc, ACK, exp_ack);
      end
      if (exp_ack != 2'b00) begin
        tests_run++;
        if (RDATA !== exp_rdata || ERR !== exp_err) begin
          tests_failed++;
          $display("FAIL random_resp cycle %0d: got rdata=%h err=%b want %h %b", cyc, RDATA, ERR, exp_rdata, exp_err);
        end
      end
      tests_run++;
      if (busy) begin
        if (PSEL !== 1'b1 || PENABLE !== (cyc != grant_edge) || PADDR !== t_ad || PWRITE !== t_wr ||
            (t_wr && PWDATA !== t_wd)) begin
          tests_failed++;
          $display("FAIL random_apb cycle %0d: got psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h want 1 %b %h %b %h",
                   cyc, PSEL, PENABLE, PADDR, PWRITE, PWDATA, (cyc != grant_edge), t_ad, t_wr, t_wd);
        end
      end else begin
        if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
          tests_failed++; $display("FAIL random_idle cycle %0d: got psel=%b pen=%b want 0 0", cyc, PSEL, PENABLE);
        end
      end
      prev_ack = exp_ack;
    end
    REQ = 2'b00;
    next_waits = 0; next_err = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) smem[i] = DW'($urandom);
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_slverr();
    test_reset_mid();
`ifdef LSRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
